// File: rtl/gcd_fsmd_core.sv
// gcd_fsmd_core: subtractive-Euclid GCD engine.
// Latches two unsigned operands on start and performs one subtract per clock.
// Reports the result and the step count through a busy/done handshake.
module gcd_fsmd_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] iter_count
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d, iter_q, iter_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Next-state and datapath control.
  // busy/done are computed from the next state, so they are registered
  // alongside it and have no combinational path from the inputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          iter_d  = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (a_q == '0) begin
          gcd_d   = b_q;
          state_d = S_DONE;
        end else if (b_q == '0) begin
          gcd_d   = a_q;
          state_d = S_DONE;
        end else if (a_q == b_q) begin
          gcd_d   = a_q;
          state_d = S_DONE;
        end else if (a_q > b_q) begin
          // The larger value is always the minuend, so this cannot underflow.
          a_d    = a_q - b_q;
          iter_d = iter_q + WIDTH'(1);
        end else begin
          b_d    = b_q - a_q;
          iter_d = iter_q + WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  // Reset aborts any calculation in progress and clears every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign gcd_out    = gcd_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_fsmd_core.sv
// tb_gcd_fsmd_core: directed vectors for gcd_fsmd_core.
// A division-based reference model is checked against the DUT every cycle.
// Hand-computed literal checks pin both the model and the DUT latency.
module tb_gcd_fsmd_core;
  localparam int W = 8;

  logic         clk, rst, start;
  logic [W-1:0] a_in, b_in;
  logic         busy, done;
  logic [W-1:0] gcd_out, iter_count;

  int total = 0;
  int bad   = 0;

  gcd_fsmd_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .gcd_out(gcd_out), .iter_count(iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: division-form Euclid.
  // The subtractive loop performs quotient-many subtractions at each division
  // step, but stops one short on the final step (at equality instead of zero).
  task automatic ref_gcd(input int unsigned a, input int unsigned b,
                         output int unsigned g, output int unsigned k);
    int unsigned x, y, t;
    x = a; y = b; k = 0;
    if (x == 0 || y == 0) begin
      g = x | y;
      return;
    end
    while (y != 0) begin
      k += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    k = k - 1;
  endtask

  // Cycle-level expectation derived from the reference result and step count.
  logic        m_valid = 1'b0;
  logic        m_busy, m_done;
  int unsigned m_gcd, m_iter, m_g, m_k;
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_gcd = 0; m_iter = 0;
    end else if (m_valid) begin
      if (!m_busy && start) begin
        ref_gcd(a_in, b_in, m_g, m_k);
        m_busy = 1'b1; m_done = 1'b0; m_iter = 0;
      end else if (m_busy) begin
        if (m_iter == m_k) begin
          m_busy = 1'b0; m_done = 1'b1; m_gcd = m_g;
        end else begin
          m_iter++;
        end
      end
    end
  end

  // Compare process: runs on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_busy", busy, m_busy);
      check("m_done", done, m_done);
      check("m_iter", iter_count, m_iter);
      check("m_gcd",  gcd_out, m_gcd);
    end
  end

  // Launch an operation; returns at the falling edge after the sampling edge S.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    a_in = $urandom_range(0, 255);
    b_in = $urandom_range(0, 255);
  endtask

  // Count edges after S until done is seen high; the wait is bounded.
  task automatic wait_done(input string name, output int edges);
    edges = 0;
    while (1) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) break;
      if (edges > 1000) begin
        check({name, "_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int g, input int k);
    int edges;
    do_start(a, b);
    wait_done(name, edges);
    check({name, "_lat"},  edges, k + 1);
    check({name, "_gcd"},  gcd_out, g);
    check({name, "_iter"}, iter_count, k);
  endtask

  initial begin
    int edges;
    rst = 1'b1; start = 1'b1; a_in = 8'd12; b_in = 8'd8;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gcd",  gcd_out, 0);
    check("rst_iter", iter_count, 0);

    run_op("basic", 8'd12, 8'd8, 4, 2);
    repeat (5) @(negedge clk);
    check("done_hold", done, 1);
    check("hold_gcd",  gcd_out, 4);

    run_op("zero_a",  8'd0, 8'd9, 9, 0);
    run_op("zero_b",  8'd9, 8'd0, 9, 0);
    run_op("zero_00", 8'd0, 8'd0, 0, 0);
    run_op("equal",   8'd7, 8'd7, 7, 0);
    run_op("worst",   8'd255, 8'd1, 1, 254);
    run_op("worst_sym", 8'd1, 8'd255, 1, 254);
    run_op("mixed",   8'd8, 8'd12, 4, 2);

    // A start pulse during CALC must be ignored.
    do_start(8'd100, 8'd3);
    repeat (5) @(negedge clk);
    start = 1'b1; a_in = 8'd10; b_in = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", edges);
    check("ignore_gcd",  gcd_out, 1);
    check("ignore_iter", iter_count, 35);

    // Restart directly from DONE: done drops on the very next cycle.
    do_start(8'd48, 8'd18);
    check("restart_done_low", done, 0);
    check("restart_busy",     busy, 1);
    wait_done("restart", edges);
    check("restart_lat",  edges, 5);
    check("restart_gcd",  gcd_out, 6);
    check("restart_iter", iter_count, 4);

    // Reset in the middle of a calculation.
    do_start(8'd200, 8'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_gcd",  gcd_out, 0);
    check("midrst_iter", iter_count, 0);
    repeat (2) @(negedge clk);
    check("midrst_idle", busy, 0);
    run_op("after_rst", 8'd21, 8'd14, 7, 2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
